// File: rtl/rxpfc_pkg.sv
// Shared constants and types for the receive-side PAUSE/PFC control frame parser.
package rxpfc_pkg;

  localparam logic [47:0] CTRL_DA  = 48'h0180_C200_0001;
  localparam logic [15:0] CTRL_ET  = 16'h8808;
  localparam logic [15:0] OP_PAUSE = 16'h0001;
  localparam logic [15:0] OP_PFC   = 16'h0101;

  localparam int HDR_BYTES = 34;
  localparam int PAUSE_MIN = 18;
  localparam int PFC_MIN   = 34;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

endpackage

// File: rtl/rxpfc_pause_timer.sv
// Per-class pause countdown: count quanta of (subq) clocks; active mirrors the next count.
module pause_timer
  import rxpfc_pkg::*;
#(
  parameter int QUANTA_W = 16,
  parameter int SUBQ_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                load,
  input  logic [QUANTA_W-1:0] load_val,
  input  logic [SUBQ_W-1:0]   subq,
  output logic                active
);

  logic [QUANTA_W-1:0] count_q, count_d;
  logic [SUBQ_W-1:0]   sub_q, sub_d, sub_last;

  // A programmed value of 0 behaves like 1, so the last sub-tick is 0 in both cases.
  assign sub_last = (subq == '0) ? '0 : subq - SUBQ_W'(1);

  always_comb begin
    count_d = count_q;
    sub_d   = sub_q;
    if (!enable) begin
      count_d = '0;
      sub_d   = '0;
    end else if (load) begin
      count_d = load_val;
      sub_d   = '0;
    end else if (count_q != '0) begin
      if (sub_q >= sub_last) begin
        sub_d   = '0;
        count_d = count_q - QUANTA_W'(1);
      end else begin
        sub_d = sub_q + SUBQ_W'(1);
      end
    end else begin
      sub_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sub_q   <= '0;
      active  <= 1'b0;
    end else begin
      count_q <= count_d;
      sub_q   <= sub_d;
      active  <= (count_d != '0);
    end
  end

endmodule

// File: rtl/rxpfc.sv
// RX MAC control parser: decodes PAUSE and PFC frames from a monitored AXIS stream
// and drives per-class pause timers, drop marking and frame statistics.
module rxpfc
  import rxpfc_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int NUM_CLASSES = 8,
  parameter int QUANTA_W    = 16,
  parameter int SUBQ_W      = 8,
  parameter int STAT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      tdata_i,
  input  logic [DATA_W/8-1:0]    tkeep_i,
  input  logic                   tvalid_i,
  input  logic                   tlast_i,
  input  logic                   tuser_i,
  output logic                   tuser_o,
  input  logic                   cfg_rx_pause_enable,
  input  logic                   cfg_pfc_enable,
  input  logic                   cfg_drop_ctrl,
  input  logic [SUBQ_W-1:0]      cfg_sub_quanta_count,
  output logic [NUM_CLASSES-1:0] rx_pause_active,
  output logic [STAT_W-1:0]      stat_pause_frames,
  output logic [STAT_W-1:0]      stat_pfc_frames
);

  localparam int BPB       = DATA_W / 8;
  localparam int CAP_BEATS = (HDR_BYTES + BPB - 1) / BPB;
  localparam int BC_W      = 3;
  localparam int LEN_W     = 8;

  state_t                 state_q;
  logic [BC_W-1:0]        beat_cnt_q, beat_idx;
  logic [HDR_BYTES*8-1:0] hdr_q, hdr_cur;
  logic [7:0]             hb [HDR_BYTES];
  logic [LEN_W-1:0]       bytes_seen;
  logic [15:0]            opcode, param;
  logic                   is_ctrl, eof, accept, pause_acc, pfc_acc;
  logic                   unused_sa;

  function automatic logic [LEN_W-1:0] popcount(input logic [BPB-1:0] keep);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int k = 0; k < BPB; k++) n = n + LEN_W'(keep[k]);
    return n;
  endfunction

  // An SOF beat always lands at offset 0, whatever the counter holds.
  assign beat_idx = (state_q == IDLE) ? '0 : beat_cnt_q;

  always_comb begin
    hdr_cur = hdr_q;
    if (tvalid_i) begin
      for (int j = 0; j < HDR_BYTES; j++) begin
        for (int b = 0; b < BPB; b++) begin
          if (int'(beat_idx) * BPB + b == j) hdr_cur[8*j +: 8] = tdata_i[8*b +: 8];
        end
      end
    end
  end

  for (genvar j = 0; j < HDR_BYTES; j++) begin : g_hb
    assign hb[j] = hdr_cur[8*j +: 8];
  end

  assign is_ctrl    = ({hb[0], hb[1], hb[2], hb[3], hb[4], hb[5]} == CTRL_DA) &&
                      ({hb[12], hb[13]} == CTRL_ET);
  assign opcode     = {hb[14], hb[15]};
  assign param      = {hb[16], hb[17]};
  assign bytes_seen = LEN_W'(beat_idx) * LEN_W'(BPB) + popcount(tkeep_i);
  assign unused_sa  = ^{hb[6], hb[7], hb[8], hb[9], hb[10], hb[11]};

  assign eof       = tvalid_i & tlast_i;
  assign accept    = eof & tuser_i & cfg_rx_pause_enable & is_ctrl;
  assign pause_acc = accept & (opcode == OP_PAUSE) & (bytes_seen >= LEN_W'(PAUSE_MIN));
  assign pfc_acc   = accept & cfg_pfc_enable & (opcode == OP_PFC) &
                     (bytes_seen >= LEN_W'(PFC_MIN));

  // Drop marking ignores length and opcode: any control frame is hidden downstream.
  assign tuser_o = tuser_i & ~(cfg_drop_ctrl & eof & is_ctrl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      hdr_q      <= '0;
    end else if (tvalid_i) begin
      hdr_q <= hdr_cur;
      case (state_q)
        IDLE:    state_q <= tlast_i ? IDLE : CAPTURE;
        default: if (tlast_i) state_q <= IDLE;
      endcase
      if (tlast_i)                           beat_cnt_q <= '0;
      else if (beat_idx < BC_W'(CAP_BEATS)) beat_cnt_q <= beat_idx + BC_W'(1);
      else                                   beat_cnt_q <= beat_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pause_frames <= '0;
      stat_pfc_frames   <= '0;
    end else begin
      if (pause_acc) stat_pause_frames <= stat_pause_frames + STAT_W'(1);
      if (pfc_acc)   stat_pfc_frames   <= stat_pfc_frames + STAT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
    logic                load;
    logic [QUANTA_W-1:0] load_val;

    assign load     = pause_acc | (pfc_acc & param[i]);
    assign load_val = pfc_acc ? QUANTA_W'({hb[18+2*i], hb[19+2*i]}) : QUANTA_W'(param);

    pause_timer #(
      .QUANTA_W (QUANTA_W),
      .SUBQ_W   (SUBQ_W)
    ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .enable   (cfg_rx_pause_enable),
      .load     (load),
      .load_val (load_val),
      .subq     (cfg_sub_quanta_count),
      .active   (rx_pause_active[i])
    );
  end

endmodule

// File: tb/tb_rxpfc.sv
// Bench for rxpfc: directed vector table, corner-case sequences, and randomized frames
// checked every cycle against a byte-queue / remaining-cycle reference model.
module tb_rxpfc;

  localparam int DW  = 64;
  localparam int BPB = DW / 8;
  localparam int NC  = 8;
  localparam logic [47:0] DA = 48'h0180_C200_0001;
  localparam logic [15:0] ET = 16'h8808;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic [BPB-1:0] tkeep = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, tuser_in = 1'b0;
  logic          tuser_out;
  logic          en = 1'b1, pfc_en = 1'b1, drop = 1'b0;
  logic [7:0]    sq = 8'd8;
  logic [NC-1:0] act;
  logic [31:0]   st_pause, st_pfc;

  int  n_tests = 0, n_fail = 0;
  bit  chk_en = 1'b0;

  rxpfc #(.DATA_W(DW), .NUM_CLASSES(NC), .QUANTA_W(16), .SUBQ_W(8), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .tdata_i(tdata), .tkeep_i(tkeep), .tvalid_i(tvalid),
    .tlast_i(tlast), .tuser_i(tuser_in), .tuser_o(tuser_out),
    .cfg_rx_pause_enable(en), .cfg_pfc_enable(pfc_en), .cfg_drop_ctrl(drop),
    .cfg_sub_quanta_count(sq), .rx_pause_active(act),
    .stat_pause_frames(st_pause), .stat_pfc_frames(st_pfc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         rem [NC];
  int         m_pause, m_pfc;
  logic [7:0] mb[$];

  initial begin
    logic [NC-1:0] ld;
    int            lv [NC];
    int            s, len;
    logic [7:0]    h [34];
    logic [15:0]   ev;
    for (int i = 0; i < NC; i++) rem[i] = 0;
    m_pause = 0;
    m_pfc   = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NC; i++) rem[i] = 0;
        m_pause = 0;
        m_pfc   = 0;
        mb.delete();
      end else begin
        ld = '0;
        for (int i = 0; i < NC; i++) lv[i] = 0;
        s = (sq == 0) ? 1 : int'(sq);
        if (tvalid) begin
          for (int k = 0; k < BPB; k++) if (tkeep[k]) mb.push_back(tdata[8*k +: 8]);
          if (tlast) begin
            len = mb.size();
            for (int k = 0; k < 34; k++) h[k] = (k < len) ? mb[k] : 8'h00;
            ev = {h[16], h[17]};
            if (tuser_in && en && len >= 14 && {h[0], h[1], h[2], h[3], h[4], h[5]} == DA &&
                {h[12], h[13]} == ET) begin
              if ({h[14], h[15]} == 16'h0001 && len >= 18) begin
                m_pause++;
                for (int i = 0; i < NC; i++) begin ld[i] = 1'b1; lv[i] = int'(ev); end
              end else if ({h[14], h[15]} == 16'h0101 && len >= 34 && pfc_en) begin
                m_pfc++;
                for (int i = 0; i < NC; i++)
                  if (ev[i]) begin ld[i] = 1'b1; lv[i] = int'({h[18+2*i], h[19+2*i]}); end
              end
            end
            mb.delete();
          end
        end
        for (int i = 0; i < NC; i++) begin
          if (!en)           rem[i] = 0;
          else if (ld[i])    rem[i] = lv[i] * s;
          else if (rem[i] > 0) rem[i] = rem[i] - 1;
        end
      end
    end
  end

  logic [NC-1:0] em;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NC; i++) em[i] = (rem[i] != 0);
      check("model_active", act, em);
      check("model_stat_pause", st_pause, m_pause);
      check("model_stat_pfc", st_pfc, m_pfc);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fr[$];

  task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                       input logic [15:0] p16, input logic [127:0] tim, input int len);
    fr.delete();
    for (int k = 0; k < len; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (k < 6)                  b = da[8*(5-k) +: 8];
      else if (k == 12)           b = et[15:8];
      else if (k == 13)           b = et[7:0];
      else if (k == 14)           b = op[15:8];
      else if (k == 15)           b = op[7:0];
      else if (k == 16)           b = p16[15:8];
      else if (k == 17)           b = p16[7:0];
      else if (k >= 18 && k < 34) b = (k % 2 == 0) ? tim[16*((k-18)/2) + 8 +: 8]
                                                   : tim[16*((k-18)/2) +: 8];
      fr.push_back(b);
    end
  endtask

  function automatic bit is_ctrl_fr();
    if (fr.size() < 14) return 1'b0;
    return ({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]} == DA) && ({fr[12], fr[13]} == ET);
  endfunction

  task automatic drive_beat(input int b, input bit good, input bit last);
    tkeep = '0;
    for (int k = 0; k < BPB; k++) begin
      tdata[8*k +: 8] = 8'($urandom);
      if (b * BPB + k < fr.size()) begin
        tdata[8*k +: 8] = fr[b*BPB + k];
        tkeep[k] = 1'b1;
      end
    end
    tvalid   = 1'b1;
    tlast    = last;
    tuser_in = good;
  endtask

  task automatic send(input bit good, output logic tu_last);
    int nb;
    nb = (fr.size() + BPB - 1) / BPB;
    tu_last = 1'bx;
    for (int b = 0; b < nb; b++) begin
      drive_beat(b, good, b == nb - 1);
      if (b == nb - 1) begin
        #1;
        tu_last = tuser_out;
      end
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tuser_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_timers();
    en = 1'b0;
    idle(1);
    en = 1'b1;
  endtask

  typedef struct {
    logic [47:0]  da;
    logic [15:0]  et, op, p16;
    logic [127:0] tim;
    int           len;
    bit           good, pfc_en, drop;
    logic [7:0]   mask;
    int           dp, df;
    bit           etu;
  } vec_t;

  localparam logic [127:0] T05 = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                  16'hFFFF, 16'h0004, 16'hFFFF, 16'h0002};
  localparam logic [127:0] T80 = {16'h0007, 112'h0};
  localparam logic [127:0] T1  = {8{16'h0001}};
  localparam logic [127:0] T8  = {64'h0, 16'd100, 48'h0};

  vec_t tbl [14];
  logic tu;
  int   n, p0, f0;
  int   cnt [NC];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{DA, ET, 16'h0001, 16'h0003, 128'h0, 64, 1, 1, 0, 8'hFF, 1, 0, 1};
    tbl[1]  = '{DA, ET, 16'h0101, 16'h0005, T05,    64, 1, 1, 0, 8'h05, 0, 1, 1};
    tbl[2]  = '{DA, ET, 16'h0101, 16'h0005, T05,    64, 0, 1, 1, 8'h00, 0, 0, 0};
    tbl[3]  = '{DA, ET, 16'h0101, 16'h0005, T05,    64, 1, 0, 1, 8'h00, 0, 0, 0};
    tbl[4]  = '{DA, ET, 16'h0001, 16'h0004, 128'h0, 17, 1, 1, 0, 8'h00, 0, 0, 1};
    tbl[5]  = '{DA, ET, 16'h0001, 16'h0005, 128'h0, 18, 1, 1, 0, 8'hFF, 1, 0, 1};
    tbl[6]  = '{DA, ET, 16'h0101, 16'h0005, T05,    33, 1, 1, 0, 8'h00, 0, 0, 1};
    tbl[7]  = '{DA, ET, 16'h0101, 16'h0080, T80,    34, 1, 1, 0, 8'h80, 0, 1, 1};
    tbl[8]  = '{DA, ET, 16'h0002, 16'h0005, 128'h0, 64, 1, 1, 1, 8'h00, 0, 0, 0};
    tbl[9]  = '{48'h0011_2233_4455, ET, 16'h0001, 16'h0005, 128'h0, 64, 1, 1, 1, 8'h00, 0, 0, 1};
    tbl[10] = '{DA, ET, 16'h0001, 16'h0000, 128'h0, 64, 1, 1, 0, 8'h00, 1, 0, 1};
    tbl[11] = '{DA, ET, 16'h0101, 16'h01FF, T1,     64, 1, 1, 0, 8'hFF, 0, 1, 1};
    tbl[12] = '{DA, ET, 16'h0101, 16'h0005, T05,    30, 1, 1, 0, 8'h00, 0, 0, 1};
    tbl[13] = '{DA, 16'h8809, 16'h0001, 16'h0005, 128'h0, 64, 1, 1, 1, 8'h00, 0, 0, 1};

    // reset state
    #12;
    check("rst_active", act, 0);
    check("rst_stat_pause", st_pause, 0);
    check("rst_stat_pfc", st_pfc, 0);
    check("rst_tuser", tuser_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // vector table
    for (int i = 0; i < 14; i++) begin
      clear_timers();
      pfc_en = tbl[i].pfc_en;
      drop   = tbl[i].drop;
      p0 = st_pause;
      f0 = st_pfc;
      build(tbl[i].da, tbl[i].et, tbl[i].op, tbl[i].p16, tbl[i].tim, tbl[i].len);
      send(tbl[i].good, tu);
      check($sformatf("vec%0d_tuser", i), tu, tbl[i].etu);
      check($sformatf("vec%0d_mask", i), act, tbl[i].mask);
      check($sformatf("vec%0d_dpause", i), 32'(st_pause - p0), tbl[i].dp);
      check($sformatf("vec%0d_dpfc", i), 32'(st_pfc - f0), tbl[i].df);
      pfc_en = 1'b1;
      drop   = 1'b0;
    end

    // PAUSE duration: quanta 3 x 8 clocks
    clear_timers();
    build(DA, ET, 16'h0001, 16'h0003, 128'h0, 64);
    send(1'b1, tu);
    check("dur_pause_start", act, 8'hFF);
    n = 0;
    while (act[0] && n < 200) begin @(posedge clk); #1; n++; end
    check("dur_pause_cycles", n, 24);

    // PFC durations: class0 2 quanta, class2 4 quanta
    clear_timers();
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    build(DA, ET, 16'h0101, 16'h0005, T05, 64);
    send(1'b1, tu);
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NC; i++) if (act[i]) cnt[i]++;
      idle(1);
    end
    for (int i = 0; i < NC; i++)
      check($sformatf("dur_pfc_cls%0d", i), cnt[i], (i == 0) ? 16 : (i == 2) ? 32 : 0);

    // reload with 0 while paused
    clear_timers();
    build(DA, ET, 16'h0001, 16'd10, 128'h0, 64);
    send(1'b1, tu);
    idle(20);
    check("reload_still_paused", act, 8'hFF);
    build(DA, ET, 16'h0001, 16'h0000, 128'h0, 64);
    send(1'b1, tu);
    check("reload_zero_unpause", act, 8'h00);

    // enable dropped while class 3 paused
    clear_timers();
    build(DA, ET, 16'h0101, 16'h0008, T8, 64);
    send(1'b1, tu);
    check("en_cls3_paused", act, 8'h08);
    en = 1'b0;
    idle(1);
    check("en_drop_clears", act, 8'h00);
    en = 1'b1;

    // async reset mid-frame, then a clean SOF
    build(DA, ET, 16'h0001, 16'd50, 128'h0, 64);
    send(1'b1, tu);
    check("arst_pre_paused", act, 8'hFF);
    build(DA, ET, 16'h0101, 16'h00FF, T1, 64);
    for (int b = 0; b < 2; b++) begin
      drive_beat(b, 1'b1, 1'b0);
      idle(1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_active", act, 0);
    check("arst_stat_pause", st_pause, 0);
    check("arst_stat_pfc", st_pfc, 0);
    tvalid = 1'b0; tkeep = '0; tuser_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    build(DA, ET, 16'h0001, 16'h0002, 128'h0, 64);
    send(1'b1, tu);
    check("arst_next_sof_mask", act, 8'hFF);
    check("arst_next_sof_stat", st_pause, 1);

    // randomized frames against the model
    en = 1'b0;
    sq = 8'($urandom_range(0, 4));
    idle(1);
    en = 1'b1;
    for (int r = 0; r < 60; r++) begin
      int           ty, len;
      logic [47:0]  da;
      logic [15:0]  op, p16;
      logic [127:0] tim;
      bit           good;
      ty  = $urandom_range(0, 3);
      da  = DA;
      op  = 16'h0001;
      p16 = 16'($urandom_range(0, 12));
      for (int c = 0; c < NC; c++) tim[16*c +: 16] = 16'($urandom_range(0, 12));
      case (ty)
        0:       len = $urandom_range(14, 40);
        1:       begin op = 16'h0101; p16 = 16'($urandom_range(0, 511)); len = $urandom_range(28, 64); end
        2:       begin op = 16'($urandom); len = $urandom_range(14, 64); end
        default: begin da = {16'h0000, 32'($urandom)}; len = $urandom_range(14, 64); end
      endcase
      good   = ($urandom_range(0, 4) != 0);
      pfc_en = ($urandom_range(0, 3) != 0);
      drop   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) clear_timers();
      build(da, ET, op, p16, tim, len);
      send(good, tu);
      check($sformatf("rnd%0d_tuser", r), tu, good && !(drop && is_ctrl_fr()));
      idle($urandom_range(0, 3));
    end
    idle(60);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
